// File: rtl/mem_bank_array.sv
// Multi-bank word memory with a shared address, per-bank write lanes and a
// burst engine that streams consecutive addresses across every bank.
module mem_bank_array #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic [NUM_BANKS-1:0]        write_en,
  input  logic [NUM_BANKS*DATA_W-1:0] data,
  input  logic                        rd_en,
  output logic [NUM_BANKS*DATA_W-1:0] q,
  output logic                        q_valid,
  input  logic                        burst_start,
  input  logic [ADDR_W-1:0]           burst_base,
  input  logic [ADDR_W:0]             burst_len,
  output logic                        burst_busy,
  output logic                        burst_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                        state_q;
  logic [ADDR_W-1:0]             cnt_q;
  logic [ADDR_W:0]               remain_q;
  logic [NUM_BANKS*DATA_W-1:0]   q_q;
  logic                          q_valid_q;
  logic                          done_q;

  logic [DATA_W-1:0]             mem [NUM_BANKS][DEPTH];

  logic [ADDR_W-1:0]             rd_addr;
  logic                          rd_fire;
  logic [NUM_BANKS*DATA_W-1:0]   rd_word;

  // A burst owns the read port; otherwise a start request swallows rd_en.
  always_comb begin
    rd_addr = (state_q == BURST) ? cnt_q : address;
    rd_fire = (state_q == BURST) || (rd_en && !burst_start);
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_word[b*DATA_W +: DATA_W] = mem[b][rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (write_en[b]) begin
          mem[b][address] <= data[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      remain_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      q_valid_q <= rd_fire;
      if (rd_fire) begin
        q_q <= rd_word;
      end
      case (state_q)
        IDLE: begin
          if (burst_start) begin
            cnt_q    <= burst_base;
            remain_q <= burst_len;
            if (burst_len != '0) begin
              state_q <= BURST;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        BURST: begin
          cnt_q    <= cnt_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign burst_busy = (state_q == BURST);
  assign burst_done = done_q;

endmodule

// File: tb/tb_mem_bank_array.sv
// Directed self-checking bench for mem_bank_array with default parameters.
module tb_mem_bank_array;

  logic        clock;
  logic        reset;
  logic [7:0]  address;
  logic [3:0]  write_en;
  logic [63:0] data;
  logic        rd_en;
  logic [63:0] q;
  logic        q_valid;
  logic        burst_start;
  logic [7:0]  burst_base;
  logic [8:0]  burst_len;
  logic        burst_busy;
  logic        burst_done;

  int total;
  int bad;

  mem_bank_array dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .write_en    (write_en),
    .data        (data),
    .rd_en       (rd_en),
    .q           (q),
    .q_valid     (q_valid),
    .burst_start (burst_start),
    .burst_base  (burst_base),
    .burst_len   (burst_len),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1ns after it.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] lanes(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] wrapPat(input logic [7:0] k);
    return lanes({8'h10, k}, {8'h20, k}, {8'h30, k}, {8'h40, k});
  endfunction

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    address = '0;
    write_en = '0;
    data = '0;
    rd_en = 1'b0;
    burst_start = 1'b0;
    burst_base = '0;
    burst_len = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_q", q, 64'h0);
    checkOutput("rst_qv", {63'h0, q_valid}, 64'h0);
    checkOutput("rst_busy", {63'h0, burst_busy}, 64'h0);
    checkOutput("rst_done", {63'h0, burst_done}, 64'h0);
    reset = 1'b0;

    // Per-bank writes at address 4
    address = 8'd4;
    data = lanes(16'd1, 16'd2, 16'd3, 16'd4);
    write_en = 4'b1110; applyStimulus();
    write_en = 4'b1101; applyStimulus();
    write_en = 4'b1011; applyStimulus();
    write_en = 4'b0111; applyStimulus();
    write_en = 4'b0000;
    data = '0;
    rd_en = 1'b1;
    applyStimulus();
    checkOutput("rd4_q", q, lanes(16'd1, 16'd2, 16'd3, 16'd4));
    checkOutput("rd4_qv", {63'h0, q_valid}, 64'h1);
    rd_en = 1'b0;
    applyStimulus();
    checkOutput("idle_qv", {63'h0, q_valid}, 64'h0);
    checkOutput("idle_qhold", q, lanes(16'd1, 16'd2, 16'd3, 16'd4));

    // Read-first collision
    address = 8'd9;
    data = lanes(16'd5, 16'd0, 16'd0, 16'd0);
    write_en = 4'b0001;
    applyStimulus();
    data = lanes(16'd6, 16'd0, 16'd0, 16'd0);
    rd_en = 1'b1;
    applyStimulus();
    checkOutput("collide_old", {48'h0, q[15:0]}, 64'd5);
    write_en = 4'b0000;
    applyStimulus();
    checkOutput("collide_new", {48'h0, q[15:0]}, 64'd6);
    rd_en = 1'b0;

    // Fill 10..13 with k+100b and run a 4-word burst
    for (int k = 10; k <= 13; k++) begin
      address = 8'(k);
      data = lanes(16'(k), 16'(k + 100), 16'(k + 200), 16'(k + 300));
      write_en = 4'b1111;
      applyStimulus();
    end
    write_en = 4'b0000;
    burst_base = 8'd10;
    burst_len = 9'd4;
    burst_start = 1'b1;
    applyStimulus();
    burst_start = 1'b0;
    checkOutput("b_e0_busy", {63'h0, burst_busy}, 64'h1);
    checkOutput("b_e0_qv", {63'h0, q_valid}, 64'h0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput("b_q", q, lanes(16'(9 + i), 16'(109 + i), 16'(209 + i), 16'(309 + i)));
      checkOutput("b_qv", {63'h0, q_valid}, 64'h1);
      checkOutput("b_busy", {63'h0, burst_busy}, {63'h0, i < 4});
      checkOutput("b_done", {63'h0, burst_done}, {63'h0, i == 4});
    end
    applyStimulus();
    checkOutput("b_end_qv", {63'h0, q_valid}, 64'h0);
    checkOutput("b_end_done", {63'h0, burst_done}, 64'h0);

    // Wrap burst with writes and restart attempts ignored
    for (int j = 0; j < 4; j++) begin
      address = 8'(254 + j);
      data = wrapPat(8'(254 + j));
      write_en = 4'b1111;
      applyStimulus();
    end
    write_en = 4'b0000;
    burst_base = 8'd254;
    burst_len = 9'd4;
    burst_start = 1'b1;
    applyStimulus();
    burst_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) begin
        write_en = 4'b1111;
        data = {64{1'b1}};
        address = 8'd255;
        burst_start = 1'b1;
        burst_base = 8'd0;
        burst_len = 9'd2;
      end
      applyStimulus();
      checkOutput("w_q", q, wrapPat(8'(253 + i)));
      checkOutput("w_qv", {63'h0, q_valid}, 64'h1);
      checkOutput("w_done", {63'h0, burst_done}, {63'h0, i == 4});
    end
    write_en = 4'b0000;
    burst_start = 1'b0;
    applyStimulus();
    checkOutput("w_norestart", {63'h0, burst_busy}, 64'h0);
    rd_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      address = 8'(254 + j);
      applyStimulus();
      checkOutput("w_intact", q, wrapPat(8'(254 + j)));
    end
    rd_en = 1'b0;
    applyStimulus();

    // Zero-length burst
    burst_len = 9'd0;
    burst_base = 8'd10;
    burst_start = 1'b1;
    applyStimulus();
    burst_start = 1'b0;
    checkOutput("z_done", {63'h0, burst_done}, 64'h1);
    checkOutput("z_qv", {63'h0, q_valid}, 64'h0);
    checkOutput("z_busy", {63'h0, burst_busy}, 64'h0);
    applyStimulus();
    checkOutput("z_done_off", {63'h0, burst_done}, 64'h0);

    // Reset on the second burst cycle
    burst_len = 9'd4;
    burst_start = 1'b1;
    applyStimulus();
    burst_start = 1'b0;
    applyStimulus();
    checkOutput("r_first", q, lanes(16'd10, 16'd110, 16'd210, 16'd310));
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("r_q", q, 64'h0);
    checkOutput("r_qv", {63'h0, q_valid}, 64'h0);
    checkOutput("r_busy", {63'h0, burst_busy}, 64'h0);
    checkOutput("r_done", {63'h0, burst_done}, 64'h0);
    applyStimulus();
    checkOutput("r_stay_idle", {63'h0, burst_busy}, 64'h0);
    address = 8'd12;
    rd_en = 1'b1;
    applyStimulus();
    rd_en = 1'b0;
    checkOutput("r_mem_kept", q, lanes(16'd12, 16'd112, 16'd212, 16'd312));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
